// File: rtl/axil_reg_pkg.sv
// Shared types and elaboration checks for the AXI4-Lite register bank.
package axil_reg_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  // Legal configurations: 32/64-bit data, at least one RW register, room for the index field.
  function automatic bit params_legal(int unsigned addr_w, int unsigned data_w,
                                      int unsigned num_rw);
    return ((data_w == 32) || (data_w == 64)) && (num_rw >= 1) && (addr_w > 3);
  endfunction

endpackage

// File: rtl/axil_reg_bank_wr.sv
// Write-channel join: accepts AW and W in any order, holds whichever arrives first, and
// emits a single-cycle commit strobe with the joined address/data/strobe.
module axil_reg_bank_wr
  import axil_reg_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [ADDR_W-1:0]   i_awaddr,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_wvalid,
  output logic                o_wready,
  output logic                o_bvalid,
  input  logic                i_bready,
  output logic                o_commit,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [DATA_W-1:0]   o_data,
  output logic [DATA_W/8-1:0] o_strb
);

  wr_state_t             r_state;
  wr_state_t             w_state_nxt;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_data;
  logic [DATA_W/8-1:0]   r_strb;

  // State register; reset discards any half-joined transaction.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= W_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Hold the half of the transaction that arrives first.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
      r_data <= '0;
      r_strb <= '0;
    end else if (r_state == W_IDLE) begin
      if (i_awvalid && !i_wvalid) begin
        r_addr <= i_awaddr;
      end
      if (i_wvalid && !i_awvalid) begin
        r_data <= i_wdata;
        r_strb <= i_wstrb;
      end
    end
  end

  // Next state, readies and commit mux (live channel wins over held copy).
  always_comb begin
    w_state_nxt = r_state;
    o_awready   = 1'b0;
    o_wready    = 1'b0;
    o_bvalid    = 1'b0;
    o_commit    = 1'b0;
    o_addr      = r_addr;
    o_data      = r_data;
    o_strb      = r_strb;
    unique case (r_state)
      W_IDLE: begin
        o_awready = !i_rst;
        o_wready  = !i_rst;
        if (!i_rst) begin
          if (i_awvalid && i_wvalid) begin
            o_commit    = 1'b1;
            o_addr      = i_awaddr;
            o_data      = i_wdata;
            o_strb      = i_wstrb;
            w_state_nxt = W_RESP;
          end else if (i_awvalid) begin
            w_state_nxt = W_HAVE_AW;
          end else if (i_wvalid) begin
            w_state_nxt = W_HAVE_W;
          end
        end
      end
      W_HAVE_AW: begin
        o_wready = 1'b1;
        if (i_wvalid) begin
          o_commit    = 1'b1;
          o_data      = i_wdata;
          o_strb      = i_wstrb;
          w_state_nxt = W_RESP;
        end
      end
      W_HAVE_W: begin
        o_awready = 1'b1;
        if (i_awvalid) begin
          o_commit    = 1'b1;
          o_addr      = i_awaddr;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        o_bvalid = 1'b1;
        if (i_bready) begin
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite register bank: NUM_RW byte-writable control registers followed by NUM_RO
// read-only status words. Define AXIL_REG_BANK_SLVERR_EN to return SLVERR for
// out-of-range accesses and writes to status words; otherwise every response is OKAY.
module axil_reg_bank
  import axil_reg_pkg::*;
#(
  parameter int unsigned ADDR_W               = 12,
  parameter int unsigned DATA_W               = 32,
  parameter int unsigned NUM_RW               = 8,
  parameter int unsigned NUM_RO               = 4,
  parameter logic [DATA_W-1:0] RESET_VAL      = '0,
  localparam int unsigned NUM_RO_W            = (NUM_RO > 0) ? NUM_RO : 1
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESET,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_W-1:0]          S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_RW*DATA_W-1:0]   reg_o,
  output logic [NUM_RW-1:0]          wr_pulse_o,
  input  logic [NUM_RO_W*DATA_W-1:0] status_i
);

  localparam int unsigned LSB = $clog2(DATA_W / 8);

  if (!params_legal(ADDR_W, DATA_W, NUM_RW)) begin : g_bad_params
    $error("axil_reg_bank: illegal ADDR_W/DATA_W/NUM_RW");
  end

  logic [DATA_W-1:0]   r_regs [NUM_RW];
  logic [NUM_RW-1:0]   r_pulse;
  resp_t               r_bresp;
  rd_state_t           r_rd_state;
  rd_state_t           w_rd_state_nxt;
  logic [DATA_W-1:0]   r_rdata;
  resp_t               r_rresp;

  logic                w_commit;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W/8-1:0] w_wstrb;
  logic [31:0]         w_widx;
  logic [31:0]         w_ridx;
  logic                w_ar_hs;
  resp_t               w_bresp_nxt;
  resp_t               w_rresp_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic                w_unused;

  axil_reg_bank_wr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr (
    .i_clk     (S_AXI_ACLK),
    .i_rst     (S_AXI_ARESET),
    .i_awaddr  (S_AXI_AWADDR),
    .i_awvalid (S_AXI_AWVALID),
    .o_awready (S_AXI_AWREADY),
    .i_wdata   (S_AXI_WDATA),
    .i_wstrb   (S_AXI_WSTRB),
    .i_wvalid  (S_AXI_WVALID),
    .o_wready  (S_AXI_WREADY),
    .o_bvalid  (S_AXI_BVALID),
    .i_bready  (S_AXI_BREADY),
    .o_commit  (w_commit),
    .o_addr    (w_waddr),
    .o_data    (w_wdata),
    .o_strb    (w_wstrb)
  );

  assign w_widx  = 32'(w_waddr[ADDR_W-1:LSB]);
  assign w_ridx  = 32'(S_AXI_ARADDR[ADDR_W-1:LSB]);
  assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Write response: only RW indices are writable.
  always_comb begin
    w_bresp_nxt = RESP_OKAY;
`ifdef AXIL_REG_BANK_SLVERR_EN
    if (w_widx >= 32'(NUM_RW)) w_bresp_nxt = RESP_SLVERR;
`endif
  end

  // Register array update with byte strobes, one-cycle write pulse and latched BRESP.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_RW; i++) r_regs[i] <= RESET_VAL;
      r_pulse <= '0;
      r_bresp <= RESP_OKAY;
    end else begin
      r_pulse <= '0;
      if (w_commit) begin
        r_bresp <= w_bresp_nxt;
        for (int i = 0; i < NUM_RW; i++) begin
          if (w_widx == 32'(i)) begin
            r_pulse[i] <= 1'b1;
            for (int b = 0; b < DATA_W / 8; b++) begin
              if (w_wstrb[b]) r_regs[i][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Read data mux: RW register, status word, or zero when out of range.
  always_comb begin
    w_rdata_nxt = '0;
    w_rresp_nxt = RESP_OKAY;
    for (int i = 0; i < NUM_RW; i++) begin
      if (w_ridx == 32'(i)) w_rdata_nxt = r_regs[i];
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (w_ridx == 32'(NUM_RW + j)) w_rdata_nxt = status_i[j*DATA_W +: DATA_W];
    end
`ifdef AXIL_REG_BANK_SLVERR_EN
    if (w_ridx >= 32'(NUM_RW + NUM_RO)) w_rresp_nxt = RESP_SLVERR;
`endif
  end

  // Read FSM state register.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_rd_state <= R_IDLE;
    end else begin
      r_rd_state <= w_rd_state_nxt;
    end
  end

  // Read FSM next state.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    unique case (r_rd_state)
      R_IDLE:  if (w_ar_hs) w_rd_state_nxt = R_RESP;
      R_RESP:  if (S_AXI_RREADY) w_rd_state_nxt = R_IDLE;
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // Read data captured at AR acceptance so it holds while RREADY is low.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rdata_nxt;
      r_rresp <= w_rresp_nxt;
    end
  end

  assign S_AXI_ARREADY = (r_rd_state == R_IDLE) && !S_AXI_ARESET;
  assign S_AXI_RVALID  = (r_rd_state == R_RESP);
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_BRESP   = r_bresp;
  assign wr_pulse_o    = r_pulse;

  for (genvar g = 0; g < NUM_RW; g++) begin : g_reg_o
    assign reg_o[g*DATA_W +: DATA_W] = r_regs[g];
  end

  // Protection bits and sub-word address bits carry no meaning here.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[LSB-1:0], w_waddr[LSB-1:0],
                      status_i};

endmodule

// File: doc/axil_reg_bank.md
# axil_reg_bank

Parametrised AXI4-Lite slave register bank for the FPGA wrapper layer: a configurable number of software-writable control registers and hardware-driven read-only status registers behind a single AXI4-Lite port. Successor to the fixed-width single-struct wrapper. Adds independent AW/W acceptance, byte-strobe writes, per-register write pulses, read-only status words and optional error responses. Sits between the host-side AXI-Lite interconnect and core/fabric control signals.

## Interface
- ADDR_W, 12: AXI address width.
- DATA_W, 32: AXI data width; 32 or 64 only.
- NUM_RW, 8: number of read/write control registers, indices 0..NUM_RW-1; ≥1.
- NUM_RO, 4: number of read-only status registers, indices NUM_RW..NUM_RW+NUM_RO-1; ≥0.
- RESET_VAL, 0: reset value of every RW register, DATA_W bits.
- S_AXI_ACLK  in  1  clock; all logic rising-edge.
- S_AXI_ARESET  in  1  reset, asynchronous, active-high.
- S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR_W/3/1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA/WSTRB/WVALID  in  DATA_W/DATA_W/8/1; S_AXI_WREADY  out  1.
- S_AXI_BRESP/BVALID  out  2/1; S_AXI_BREADY  in  1.
- S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR_W/3/1; S_AXI_ARREADY  out  1.
- S_AXI_RDATA/RRESP/RVALID  out  DATA_W/2/1; S_AXI_RREADY  in  1.
- reg_o  out  NUM_RW*DATA_W  RW register contents; register i at [i*DATA_W +: DATA_W].
- wr_pulse_o  out  NUM_RW  one-cycle pulse per committed write to RW register i.
- status_i  in  max(NUM_RO,1)*DATA_W  RO register values, sampled at read acceptance.

## Operation
- Decode: LSB = log2(DATA_W/8); index = ADDR[ADDR_W-1:LSB]; bits below LSB ignored. AxPROT ignored.
- Write FSM: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE: AWREADY=WREADY=1. AW and W in same cycle -> commit, go W_RESP. AW only -> latch address, W_HAVE_AW. W only -> latch data/strobe, W_HAVE_W.
  - W_HAVE_AW: AWREADY=0, WREADY=1; W handshake -> commit, W_RESP. W_HAVE_W symmetric.
  - W_RESP: AWREADY=WREADY=0, BVALID=1; BREADY -> W_IDLE.
- Commit: RW index -> byte lanes with WSTRB=1 updated, others kept; wr_pulse_o[index]=1 for one cycle. RO or out-of-range index -> no state change, no pulse.
- Read FSM: R_IDLE (ARREADY=1), R_RESP (RVALID=1, ARREADY=0). ARVALID in R_IDLE -> RDATA/RRESP registered, R_RESP; RREADY -> R_IDLE.
- Read data: RW index -> register; RO index -> status_i word; out-of-range -> 0.
- Read and write channels independent; same-cycle read acceptance and write commit to same register returns the pre-write value.
- RDATA/RRESP/BRESP stable while VALID high and READY low.

## Timing
- Write latency: BVALID and reg_o/wr_pulse_o update 1 cycle after the final of the AW/W handshakes. Max throughput one write per 2 cycles with BREADY tied high.
- Read latency: RVALID 1 cycle after AR handshake; one read per 2 cycles.
- Reset asserted: BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, reg_o=RESET_VAL replicated, wr_pulse_o=0, FSMs to idle. All READYs forced 0 while reset high, 1 from first cycle after deassertion.
- Reset mid-transaction: latched AW/W and pending B/R discarded; no write committed.
- VALID deassert without handshake is a master protocol violation; no recovery required.

## Configuration
- AXIL_REG_BANK_SLVERR_EN defined: out-of-range read/write, or write to RO index, returns SLVERR (2'b10) on BRESP/RRESP.
- Undefined: all responses OKAY (2'b00); data and side-effect behaviour unchanged.

## Structure
- Package axil_reg_pkg: resp_t enum (RESP_OKAY=2'b00, RESP_SLVERR=2'b10), wr_state_t, rd_state_t, parameter legality checks.
- Sub-module axil_reg_bank_wr: write-channel join FSM and AW/W holding registers, producing one commit strobe with index/data/strobe. Decode, register array and read path in top.

## Test plan
- Reset then read index 0 -> RVALID one cycle after AR, RDATA=RESET_VAL, RRESP=OKAY.
- AW addr 0x004 and W 0xDEADBEEF, WSTRB 0xF same cycle -> next cycle reg_o word1=0xDEADBEEF, wr_pulse_o=0x02, BVALID=1.
- W 0x000000AA WSTRB 0x1 three cycles before AW addr 0x004 -> word1 becomes 0xDEADBEAA; pulse only after AW.
- status_i word0=0x12345678, read addr 0x020 (NUM_RW=8) -> RDATA=0x12345678; write to 0x020 -> no change, BRESP=SLVERR with macro, OKAY without.
- Read addr 0xFFC -> RDATA=0, RRESP=SLVERR with macro; hold RREADY low 5 cycles -> RVALID/RDATA stable, ARREADY=0.
- Assert reset during W_HAVE_AW -> after release, BVALID=0, registers at RESET_VAL, new full write succeeds.
